// File: rtl/data_bus_arbiter_if.sv
// data_bus_arbiter_if: RAM-side bus and accelerator FIFO-pair signals of data_bus_arbiter
interface data_bus_arbiter_if #(
  parameter int DATA_W = 128,
  parameter int NUM_CH = 3
);
  localparam int GW = $clog2(NUM_CH);
  logic [NUM_CH-1:0] ch_enable, to_empty, to_full, from_empty, from_full;
  logic [NUM_CH*DATA_W-1:0] ch_data_in;
  logic [DATA_W-1:0] bus_in, bus_out, ch_data_out;
  logic bus_in_ready, bus_out_valid, grant_dir, busy;
  logic [NUM_CH-1:0] put_req, get_req;
  logic [GW-1:0] grant_ch;
  modport master (
    input  ch_enable, to_empty, to_full, from_empty, from_full, ch_data_in, bus_in,
    output bus_in_ready, bus_out, bus_out_valid, ch_data_out, put_req, get_req, grant_ch, grant_dir, busy
  );
  modport slave (
    output ch_enable, to_empty, to_full, from_empty, from_full, ch_data_in, bus_in,
    input  bus_in_ready, bus_out, bus_out_valid, ch_data_out, put_req, get_req, grant_ch, grant_dir, busy
  );
endinterface

// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: bursts words between RAM bus and NUM_CH FIFO pairs; DBA_FAIR_RR_EN selects round-robin over fixed priority
module data_bus_arbiter #(
  parameter int DATA_W = 128,
  parameter int NUM_CH = 3,
  parameter int BURST_LEN = 4
) (
  input logic clk,
  input logic rst,
  data_bus_arbiter_if.master bus
);
  localparam int GW = $clog2(NUM_CH);
  localparam int CW = $clog2(BURST_LEN + 1);
  typedef enum logic [1:0] {IDLE, XFER, FLUSH} state_t;
  state_t state_q, state_d;
  logic [GW-1:0] gch_q, gch_d, sel;
  logic gdir_q, gdir_d, bov_q, bov_d, sel_fill, xfer, fill_go, drain_go, beat;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0] elig, oh, put_q, put_d, get_oh;
  logic [DATA_W-1:0] bo_q, bo_d, cdo_q, cdo_d;
  assign elig = bus.ch_enable & (~bus.from_empty | ~bus.to_full);
`ifdef DBA_FAIR_RR_EN
  logic [GW-1:0] ptr_q, ptr_d, cand;
  always_comb begin
    sel = '0;
    cand = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand = GW'((int'(ptr_q) + k) % NUM_CH);
      sel = elig[cand] ? cand : sel;
    end
  end
  assign ptr_d = (state_q == FLUSH) ? ((int'(gch_q) == NUM_CH - 1) ? '0 : gch_q + 1'b1) : ptr_q;
  always_ff @(posedge clk) ptr_q <= rst ? '0 : ptr_d;
`else
  always_comb begin
    sel = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) sel = elig[k] ? GW'(k) : sel;
  end
`endif
  assign sel_fill = ~bus.from_full[sel] & ~bus.to_full[sel] & (bus.to_empty[sel] | bus.from_empty[sel]);
  assign xfer = state_q == XFER;
  assign fill_go = bus.ch_enable[gch_q] & ~bus.to_full[gch_q];
  assign drain_go = bus.ch_enable[gch_q] & ~bus.from_empty[gch_q];
  assign beat = xfer & (gdir_q ? fill_go : drain_go);
  assign oh = {{(NUM_CH-1){1'b0}}, 1'b1} << gch_q;
  always_comb begin
    state_d = state_q;
    gch_d = gch_q;
    gdir_d = gdir_q;
    cnt_d = cnt_q;
    if (state_q == IDLE && |elig) begin
      state_d = XFER;
      gch_d = sel;
      gdir_d = sel_fill;
      cnt_d = '0;
    end
    if (xfer) begin
      cnt_d = cnt_q + CW'(beat);
      state_d = (!beat || cnt_q + 1'b1 == CW'(BURST_LEN)) ? FLUSH : XFER;
    end
    if (state_q == FLUSH) state_d = IDLE;
    put_d = (beat && gdir_q) ? oh : '0;
    get_oh = (beat && !gdir_q) ? oh : '0;
    bov_d = beat & ~gdir_q;
    bo_d = bov_d ? bus.ch_data_in[int'(gch_q)*DATA_W +: DATA_W] : bo_q;
    cdo_d = (beat && gdir_q) ? bus.bus_in : cdo_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gch_q <= '0;
      gdir_q <= 1'b0;
      cnt_q <= '0;
      put_q <= '0;
      bov_q <= 1'b0;
      bo_q <= '0;
      cdo_q <= '0;
    end else begin
      state_q <= state_d;
      gch_q <= gch_d;
      gdir_q <= gdir_d;
      cnt_q <= cnt_d;
      put_q <= put_d;
      bov_q <= bov_d;
      bo_q <= bo_d;
      cdo_q <= cdo_d;
    end
  end
  assign bus.bus_in_ready = xfer & gdir_q & fill_go;
  assign bus.get_req = get_oh;
  assign bus.put_req = put_q;
  assign bus.bus_out = bo_q;
  assign bus.bus_out_valid = bov_q;
  assign bus.ch_data_out = cdo_q;
  assign bus.grant_ch = gch_q;
  assign bus.grant_dir = gdir_q;
  assign bus.busy = xfer;
endmodule

// File: doc/data_bus_arbiter.md
# data_bus_arbiter

Parametrised successor to the three-accelerator data bus controller. Moves data between the shared RAM-side data bus and NUM_CH accelerator FIFO pairs. It replaces the tri-state bus with muxed, registered paths. It arbitrates among all enabled channels instead of assuming one-hot enables, and it moves bounded bursts with real put/get handshakes driven by the FIFO full/empty flags.

## Interface
Parameters:
- DATA_W, 128, bus and FIFO word width
- NUM_CH, 3, number of accelerator channels (≥2)
- BURST_LEN, 4, maximum words moved per grant (≥1)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ch_enable  in  NUM_CH  channel i may be serviced
- to_empty, to_full  in  NUM_CH each  status of router→accelerator FIFO i
- from_empty, from_full  in  NUM_CH each  status of accelerator→router FIFO i
- ch_data_in  in  NUM_CH*DATA_W  read data of from-FIFO i, slice [i*DATA_W +: DATA_W]
- bus_in  in  DATA_W  RAM-side write data into router
- bus_in_ready  out  1  router accepts bus_in this cycle
- bus_out  out  DATA_W  data to RAM side (registered)
- bus_out_valid  out  1  bus_out holds a new word this cycle
- ch_data_out  out  DATA_W  write data broadcast to all to-FIFOs (registered)
- put_req  out  NUM_CH  write strobe to to-FIFO i
- get_req  out  NUM_CH  read strobe to from-FIFO i
- grant_ch  out  $clog2(NUM_CH)  currently granted channel
- grant_dir  out  1  1 = fill (to accelerator), 0 = drain (from accelerator)
- busy  out  1  state is XFER

## Operation
- FSM states: IDLE, XFER, FLUSH.
- Eligibility of channel i: ch_enable[i] and (drain_ok = !from_empty[i] or fill_ok = !to_full[i]).
- Direction for channel i, first match wins:
  1. from_full → drain
  2. to_empty and fill_ok → fill
  3. drain_ok → drain
  4. fill_ok → fill
- IDLE: if any channel is eligible, pick one per the arbitration rule (see Configuration). Latch grant_ch and grant_dir, clear the beat counter, go to XFER.
- XFER fill: bus_in_ready = !to_full[grant_ch] & ch_enable[grant_ch], combinational. On a cycle with bus_in_ready, bus_in is captured. The next cycle has ch_data_out = captured word and put_req[grant_ch] = 1 for exactly one cycle.
- XFER drain: while !from_empty[grant_ch] & ch_enable[grant_ch], assert get_req[grant_ch]. The FIFO returns data one cycle later. That cycle registers ch_data_in slice into bus_out, and bus_out_valid = 1.
- Beat counter ($clog2(BURST_LEN+1) bits) increments per accepted beat. XFER → FLUSH when:
  - count reaches BURST_LEN, or
  - the direction condition fails (to_full / from_empty), or
  - ch_enable[grant_ch] drops.
- FLUSH lasts one cycle and retires the last put/bus_out_valid. Then go to IDLE. The round-robin pointer becomes grant_ch+1 mod NUM_CH.
- At most one put_req or get_req bit is high in any cycle. put_req and get_req are never both high.

## Timing
- Reset (rst=1 at a clock edge): state IDLE, pointer 0, beat count 0. All outputs are 0: put_req, get_req, bus_in_ready, bus_out, bus_out_valid, ch_data_out, grant_ch, grant_dir, busy. Reset mid-burst drops the in-flight word; no strobe is issued after the reset edge.
- Arbitration latency: 1 cycle from eligibility seen in IDLE to busy = 1.
- Fill: put_req occurs 1 cycle after bus_in acceptance. Drain: bus_out_valid occurs 1 cycle after get_req.
- Throughput: 1 word per cycle within a burst. Re-arbitration overhead is 2 cycles (FLUSH + IDLE).
- Flags are sampled every XFER cycle. A flag change stops the burst on that same cycle: no strobe is issued into a full FIFO or from an empty one.
- No eligible channel: remain in IDLE, all strobes 0.

## Configuration
- DBA_FAIR_RR_EN defined: round-robin arbitration. The search starts at the pointer and wraps to index 0.
- DBA_FAIR_RR_EN undefined: fixed priority, lowest eligible index wins. The pointer logic is removed.

## Test plan
- Reset mid-drain burst: every output is 0 on the cycle after the rst edge; no get_req follows.
- NUM_CH=3, only ch1 enabled, from_full[1]=1, from_empty=0: grant_ch=1, grant_dir=0. Four get_req[1] pulses on consecutive cycles. bus_out_valid follows each pulse one cycle later with ch_data_in slice 1. FLUSH, then IDLE.
- ch0 enabled, to_empty[0]=1, bus_in=0xA5…: 4 accepts, then 4 put_req[0] with ch_data_out matching. to_full[0] asserted after beat 2 ends the burst at 2 beats.
- All 3 channels enabled and drain-eligible, DBA_FAIR_RR_EN defined: grants go 0,1,2,0. Undefined: grants go 0,0,0.
- ch2 to_full=1 and from_empty=1: never granted; bus_in_ready and all strobes stay 0.
- ch_enable[1] drops on beat 2 of a fill: bus_in_ready deasserts that cycle. The pending put_req retires in FLUSH, then IDLE.
